// File: rtl/da_row_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : da_row_sched_pkg
// Description : Shared types and constants for the DA row scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package da_row_sched_pkg;

    // Width of the row result produced by the DA row engine
    localparam int c_eng_yw = 19;

    // Owner encoding used for res_owner and the round-robin pointer
    localparam logic c_owner_a = 1'b0;
    localparam logic c_owner_b = 1'b1;

    // Scheduler FSM states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_WAIT    = 3'd2,
        ST_STORE   = 3'd3,
        ST_RECOVER = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/da_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : da_rr_arb2
// Description : Two-input round-robin arbiter. The pointer remembers which
//               requester was served last and is advanced only on i_upd.
// Revision    : 1.0 - initial release
// ============================================================================
module da_rr_arb2
    import da_row_sched_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req_a,
    input  logic i_req_b,
    input  logic i_upd,
    input  logic i_owner,
    output logic o_gnt_a,
    output logic o_gnt_b
);

    // High when B has priority on a tie (A was served last)
    logic r_prio_b;

    // Pointer register: favour whichever requester was not served last
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio_b <= 1'b0;
        end else if (i_upd) begin
            r_prio_b <= (i_owner == c_owner_a);
        end
    end

    // A lone request always wins; a tie goes to the favoured requester
    assign o_gnt_a = i_req_a & (~i_req_b | ~r_prio_b);
    assign o_gnt_b = i_req_b & (~i_req_a |  r_prio_b);

endmodule
`default_nettype wire

// File: rtl/da_row_sched.sv
`default_nettype none
// ============================================================================
// Module      : da_row_sched
// Description : Arbitrates vector jobs from two requesters and issues NROWS
//               rows per job to a shared DA row engine, returning truncated
//               row results with owner tags and an engine timeout guard.
// Revision    : 1.0 - initial release
// ============================================================================
module da_row_sched
    import da_row_sched_pkg::*;
#(
    parameter int NROWS = 8,
    parameter int YW    = 12,
    parameter int TMO   = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_a,
    input  logic                req_b,
    input  logic [63:0]         xa,
    input  logic [63:0]         xb,
    output logic                ack_a,
    output logic                ack_b,
    output logic [63:0]         eng_x,
    output logic [4:0]          eng_row,
    output logic                eng_reset,
    output logic                eng_start,
    input  logic                eng_done,
    input  logic [c_eng_yw-1:0] eng_y,
    output logic                res_valid,
    output logic                res_owner,
    output logic [3:0]          res_row,
    output logic [YW-1:0]       res_data,
    output logic                job_done,
    output logic                err,
    output logic                busy
);

    state_t        r_state;
    state_t        w_next;

    logic          w_gnt_a;
    logic          w_gnt_b;
    logic          w_capture;
    logic          w_row_last;
    logic          w_tmo_hit;
    logic          w_done_evt;
    logic          w_tmo_evt;
    logic          w_eng_reset;
    logic          w_eng_start;

    logic [63:0]   r_eng_x;
    logic [3:0]    r_row;
    logic          r_owner;
    logic [15:0]   r_tmo_cnt;
    logic          r_ack_a;
    logic          r_ack_b;
    logic          r_res_valid;
    logic          r_res_owner;
    logic [3:0]    r_res_row;
    logic [YW-1:0] r_res_data;
    logic          r_job_done;
    logic          r_err;
    logic          r_busy;

    da_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (reset),
        .i_req_a (req_a),
        .i_req_b (req_b),
        .i_upd   (w_done_evt | w_tmo_evt),
        .i_owner (r_owner),
        .o_gnt_a (w_gnt_a),
        .o_gnt_b (w_gnt_b)
    );

    assign w_capture  = (r_state == ST_IDLE) && (w_gnt_a || w_gnt_b);
    assign w_row_last = (r_row == 4'(NROWS - 1));
    // Counter holds cycles elapsed since LAUNCH (or STORE), so a hit here
    // lands err exactly TMO cycles after that point
    assign w_tmo_hit  = (r_tmo_cnt >= 16'(TMO - 1));

    // State register; reset forces IDLE so the engine is held in reset at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and engine handshake outputs
    always_comb begin
        w_next      = r_state;
        w_eng_reset = 1'b1;
        w_eng_start = 1'b0;
        w_done_evt  = 1'b0;
        w_tmo_evt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_a || req_b) begin
                    w_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                w_eng_reset = 1'b0;
                w_eng_start = 1'b1;
                w_next      = ST_WAIT;
            end
            ST_WAIT: begin
                w_eng_reset = 1'b0;
                w_eng_start = 1'b1;
                if (eng_done) begin
                    w_next = ST_STORE;
                end else if (w_tmo_hit) begin
                    w_tmo_evt = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            ST_STORE: begin
                w_next = ST_RECOVER;
            end
            ST_RECOVER: begin
                if (!eng_done) begin
                    if (w_row_last) begin
                        w_done_evt = 1'b1;
                        w_next     = ST_IDLE;
                    end else begin
                        w_next = ST_LAUNCH;
                    end
                end else if (w_tmo_hit) begin
                    w_tmo_evt = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Job datapath: capture, row stepping, result registers and pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_eng_x     <= 64'd0;
            r_row       <= 4'd0;
            r_owner     <= c_owner_a;
            r_ack_a     <= 1'b0;
            r_ack_b     <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_owner <= c_owner_a;
            r_res_row   <= 4'd0;
            r_res_data  <= '0;
            r_job_done  <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_ack_a     <= 1'b0;
            r_ack_b     <= 1'b0;
            r_res_valid <= 1'b0;
            r_job_done  <= w_done_evt;
            r_err       <= w_tmo_evt;
            if (w_capture) begin
                r_eng_x <= w_gnt_b ? xb : xa;
                r_owner <= w_gnt_b ? c_owner_b : c_owner_a;
                r_ack_a <= w_gnt_a & ~w_gnt_b;
                r_ack_b <= w_gnt_b;
                r_row   <= 4'd0;
                r_busy  <= 1'b1;
            end
            if (r_state == ST_STORE) begin
                r_res_valid <= 1'b1;
                r_res_data  <= eng_y[c_eng_yw-1 -: YW];
                r_res_row   <= r_row;
                r_res_owner <= r_owner;
            end
            if ((r_state == ST_RECOVER) && !eng_done && !w_row_last) begin
                r_row <= r_row + 4'd1;
            end
            if (w_done_evt || w_tmo_evt) begin
                r_busy <= 1'b0;
            end
        end
    end

    // Timeout counter: runs only while waiting on the engine
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo_cnt <= 16'd0;
        end else if ((r_state == ST_LAUNCH) || (r_state == ST_STORE)) begin
            r_tmo_cnt <= 16'd1;
        end else if ((r_state == ST_WAIT) || (r_state == ST_RECOVER)) begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end else begin
            r_tmo_cnt <= 16'd0;
        end
    end

    // Result LSBs below the truncation point are intentionally dropped
    generate
        if (YW < c_eng_yw) begin : g_unused_lsbs
            logic w_unused_lsbs;
            assign w_unused_lsbs = ^eng_y[c_eng_yw-YW-1:0];
        end
    endgenerate

    assign ack_a     = r_ack_a;
    assign ack_b     = r_ack_b;
    assign eng_x     = r_eng_x;
    assign eng_row   = {1'b0, r_row};
    assign eng_reset = w_eng_reset;
    assign eng_start = w_eng_start;
    assign res_valid = r_res_valid;
    assign res_owner = r_res_owner;
    assign res_row   = r_res_row;
    assign res_data  = r_res_data;
    assign job_done  = r_job_done;
    assign err       = r_err;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_da_row_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_da_row_sched
// Description : Self-checking bench for da_row_sched with a behavioural
//               DA row engine (programmable latency, done hold, stuck mode).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_da_row_sched;
    import da_row_sched_pkg::*;

    localparam int NROWS = 8;
    localparam int YW    = 12;
    localparam int TMO   = 255;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_a, req_b;
    logic [63:0]   xa, xb;
    logic          ack_a, ack_b;
    logic [63:0]   eng_x;
    logic [4:0]    eng_row;
    logic          eng_reset, eng_start;
    logic          eng_done = 1'b0;
    logic [18:0]   eng_y;
    logic          res_valid, res_owner;
    logic [3:0]    res_row;
    logic [YW-1:0] res_data;
    logic          job_done, err, busy;

    always #5 clk = ~clk;

    da_row_sched #(.NROWS(NROWS), .YW(YW), .TMO(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_a     (req_a),
        .req_b     (req_b),
        .xa        (xa),
        .xb        (xb),
        .ack_a     (ack_a),
        .ack_b     (ack_b),
        .eng_x     (eng_x),
        .eng_row   (eng_row),
        .eng_reset (eng_reset),
        .eng_start (eng_start),
        .eng_done  (eng_done),
        .eng_y     (eng_y),
        .res_valid (res_valid),
        .res_owner (res_owner),
        .res_row   (res_row),
        .res_data  (res_data),
        .job_done  (job_done),
        .err       (err),
        .busy      (busy)
    );

    // Behavioural engine: done rises e_lat cycles after start, falls e_hold
    // cycles after eng_reset is seen; e_never keeps done low forever
    int e_lat   = 20;
    int e_hold  = 0;
    bit e_never = 1'b0;
    int e_cnt   = 0;
    int e_hcnt  = 0;

    always @(posedge clk) begin
        if (eng_reset) begin
            e_cnt <= 0;
            if (eng_done) begin
                if (e_hcnt >= e_hold) begin
                    eng_done <= 1'b0;
                    e_hcnt   <= 0;
                end else begin
                    e_hcnt <= e_hcnt + 1;
                end
            end
        end else if (eng_start && !e_never) begin
            e_cnt <= e_cnt + 1;
            if (e_cnt + 1 >= e_lat) eng_done <= 1'b1;
        end
    end

    typedef struct {
        logic          owner;
        logic [3:0]    row;
        logic [YW-1:0] data;
        int            cyc;
    } res_t;

    typedef struct {
        logic          rb;
        logic [63:0]   x;
        logic [18:0]   y;
        int            lat;
        logic [YW-1:0] data;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_ack_a = 0, n_ack_b = 0, n_done = 0, n_err = 0, n_bad_launch = 0;
    int   c_launch = 0, c_err = 0;
    logic err_eng_reset = 1'b0;
    logic prev_start = 1'b0;
    res_t resq[$];
    int   lq[$];
    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and record every observable event of that cycle
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (ack_a) n_ack_a++;
        if (ack_b) n_ack_b++;
        if (res_valid) resq.push_back('{res_owner, res_row, res_data, cyc});
        if (job_done) n_done++;
        if (err) begin
            n_err++;
            c_err = cyc;
            err_eng_reset = eng_reset;
        end
        if (eng_start && !prev_start) begin
            c_launch = cyc;
            lq.push_back(int'(eng_row));
            if (eng_done) n_bad_launch++;
        end
        prev_start = eng_start;
    endtask

    // Wait for the owner's ack, drop its request, run the job to job_done
    // and verify every row result and the row-to-row period
    task automatic run_job(input logic owner, input logic [YW-1:0] exp_data,
                           input logic [63:0] exp_x, input int period, input string tag);
        int a0, d0, e0, k;
        a0 = owner ? n_ack_b : n_ack_a;
        d0 = n_done;
        e0 = n_err;
        resq.delete();
        lq.delete();
        k = 0;
        while (((owner ? n_ack_b : n_ack_a) == a0) && k < 300) begin
            tick();
            k++;
        end
        check({tag, " ack"}, 64'((owner ? n_ack_b : n_ack_a)), 64'(a0 + 1));
        if (owner) req_b = 1'b0; else req_a = 1'b0;
        check({tag, " eng_x"}, eng_x, exp_x);
        k = 0;
        while (n_done == d0 && n_err == e0 && k < 3000) begin
            tick();
            k++;
        end
        check({tag, " job_done"}, 64'(n_done), 64'(d0 + 1));
        check({tag, " err"}, 64'(n_err), 64'(e0));
        check({tag, " busy"}, 64'(busy), 64'(0));
        check({tag, " owner@done"}, 64'(res_owner), 64'(owner));
        check({tag, " nres"}, 64'(resq.size()), 64'(NROWS));
        check({tag, " nlaunch"}, 64'(lq.size()), 64'(NROWS));
        for (int i = 0; i < resq.size(); i++) begin
            check($sformatf("%s r%0d owner", tag, i), 64'(resq[i].owner), 64'(owner));
            check($sformatf("%s r%0d row", tag, i), 64'(resq[i].row), 64'(i));
            check($sformatf("%s r%0d data", tag, i), 64'(resq[i].data), 64'(exp_data));
            if (i > 0)
                check($sformatf("%s r%0d period", tag, i), 64'(resq[i].cyc - resq[i-1].cyc), 64'(period));
        end
        for (int i = 0; i < lq.size(); i++)
            check($sformatf("%s launch%0d eng_row", tag, i), 64'(lq[i]), 64'(i));
    endtask

    initial begin
        int k, d0, e0, b0;

        vecs[0] = '{1'b0, 64'h0123_4567_89AB_CDEF, 19'h7FF80, 5, 12'hFFF};
        vecs[1] = '{1'b1, 64'hFEDC_BA98_7654_3210, 19'h00080, 1, 12'h001};
        vecs[2] = '{1'b0, 64'h8000_0000_0000_0001, 19'h40000, 7, 12'h800};
        vecs[3] = '{1'b1, 64'h5A5A_A5A5_0F0F_F0F0, 19'h2AAAA, 3, 12'h555};
        vecs[4] = '{1'b0, 64'hFFFF_0000_FFFF_0000, 19'h0007F, 2, 12'h000};

        reset = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        xa    = 64'd0;
        xb    = 64'd0;
        eng_y = 19'd0;
        repeat (3) tick();

        // Reset state
        check("rst ack_a", 64'(ack_a), 64'(0));
        check("rst ack_b", 64'(ack_b), 64'(0));
        check("rst res_valid", 64'(res_valid), 64'(0));
        check("rst job_done", 64'(job_done), 64'(0));
        check("rst err", 64'(err), 64'(0));
        check("rst busy", 64'(busy), 64'(0));
        check("rst eng_reset", 64'(eng_reset), 64'(1));
        check("rst eng_start", 64'(eng_start), 64'(0));
        check("rst eng_x", eng_x, 64'd0);
        check("rst eng_row", 64'(eng_row), 64'(0));
        check("rst res_data", 64'(res_data), 64'(0));
        reset = 1'b0;
        tick();

        // Simultaneous pair after reset: A first, B held and served after
        xa    = 64'h0706_0504_0302_0100;
        xb    = 64'h8877_6655_4433_2211;
        eng_y = 19'h7FF80;
        e_lat = 20;
        req_a = 1'b1;
        req_b = 1'b1;
        run_job(1'b0, 12'hFFF, 64'h0706_0504_0302_0100, 23, "pairA");
        check("pairA no ack_b", 64'(n_ack_b), 64'(0));
        run_job(1'b1, 12'hFFF, 64'h8877_6655_4433_2211, 23, "pairB");

        // Table of single-requester jobs
        for (int i = 0; i < 5; i++) begin
            eng_y = vecs[i].y;
            e_lat = vecs[i].lat;
            if (vecs[i].rb) begin
                xb    = vecs[i].x;
                req_b = 1'b1;
            end else begin
                xa    = vecs[i].x;
                req_a = 1'b1;
            end
            run_job(vecs[i].rb, vecs[i].data, vecs[i].x, vecs[i].lat + 3, $sformatf("vec%0d", i));
        end

        // Second simultaneous pair: A was served last, so B wins the tie
        xa    = 64'h1111_2222_3333_4444;
        xb    = 64'h5555_6666_7777_8888;
        eng_y = 19'h00080;
        e_lat = 4;
        req_a = 1'b1;
        req_b = 1'b1;
        run_job(1'b1, 12'h001, 64'h5555_6666_7777_8888, 7, "pair2B");
        run_job(1'b0, 12'h001, 64'h1111_2222_3333_4444, 7, "pair2A");

        // Engine holds done 3 cycles into reset: launch waits for done low
        e_hold = 3;
        e_lat  = 6;
        xa     = 64'hCAFE_F00D_DEAD_BEEF;
        eng_y  = 19'h7FF80;
        req_a  = 1'b1;
        run_job(1'b0, 12'hFFF, 64'hCAFE_F00D_DEAD_BEEF, 12, "hold");
        check("hold no launch while done", 64'(n_bad_launch), 64'(0));
        e_hold = 0;

        // One-cycle req_b pulse while busy is never acked
        b0    = n_ack_b;
        d0    = n_done;
        e_lat = 5;
        req_a = 1'b1;
        k = 0;
        while (!busy && k < 50) begin tick(); k++; end
        req_a = 1'b0;
        repeat (3) tick();
        req_b = 1'b1;
        tick();
        req_b = 1'b0;
        k = 0;
        while (n_done == d0 && k < 500) begin tick(); k++; end
        repeat (20) tick();
        check("pulse job_done", 64'(n_done), 64'(d0 + 1));
        check("pulse no ack_b", 64'(n_ack_b), 64'(b0));

        // Engine never completes: err exactly TMO cycles after LAUNCH
        e_never = 1'b1;
        d0      = n_done;
        e0      = n_err;
        req_a   = 1'b1;
        k = 0;
        while (!ack_a && k < 50) begin tick(); k++; end
        req_a = 1'b0;
        k = 0;
        while (n_err == e0 && k < 600) begin tick(); k++; end
        check("tmo err count", 64'(n_err), 64'(e0 + 1));
        check("tmo latency", 64'(c_err - c_launch), 64'(TMO));
        check("tmo eng_reset", 64'(err_eng_reset), 64'(1));
        check("tmo busy", 64'(busy), 64'(0));
        repeat (5) tick();
        check("tmo no job_done", 64'(n_done), 64'(d0));
        e_never = 1'b0;

        // Reset during row 4 WAIT discards the job silently
        e_lat = 20;
        eng_y = 19'h40000;
        xa    = 64'h0F0F_0F0F_0F0F_0F0F;
        req_a = 1'b1;
        resq.delete();
        k = 0;
        while (!ack_a && k < 50) begin tick(); k++; end
        req_a = 1'b0;
        k = 0;
        while (resq.size() < 4 && k < 500) begin tick(); k++; end
        check("midrst rows before", 64'(resq.size()), 64'(4));
        k = 0;
        while (!eng_start && k < 50) begin tick(); k++; end
        check("midrst row4 launch", 64'(eng_row), 64'(4));
        repeat (5) tick();
        d0 = n_done;
        e0 = n_err;
        #2;
        reset = 1'b1;
        #1;
        check("midrst eng_reset now", 64'(eng_reset), 64'(1));
        check("midrst eng_start now", 64'(eng_start), 64'(0));
        check("midrst busy now", 64'(busy), 64'(0));
        repeat (2) tick();
        reset = 1'b0;
        repeat (30) tick();
        check("midrst no more res", 64'(resq.size()), 64'(4));
        check("midrst no job_done", 64'(n_done), 64'(d0));
        check("midrst no err", 64'(n_err), 64'(e0));
        req_a = 1'b1;
        run_job(1'b0, 12'h800, 64'h0F0F_0F0F_0F0F_0F0F, 23, "postrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
